// File: rtl/proc_concat_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : proc_concat_arbiter                                             |
// | Round-robin arbiter that packs the granted {a, c[1:0], b} field set into |
// | a single registered output word with valid/ready handshake.              |
// | Optional: define PROC_CONCAT_ARB_STATS_EN to add a saturating transfer   |
// | counter on port stat_count.                                              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module proc_concat_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_a,
    input  logic [NUM_REQ-1:0]     req_b,
    input  logic [2*NUM_REQ-1:0]   req_c,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2:0]             out_2,
    output logic                   out_1,
    output logic [ID_W-1:0]        out_id
`ifdef PROC_CONCAT_ARB_STATS_EN
    ,
    output logic [15:0]            stat_count
`endif
);

    localparam logic [ID_W:0]   c_NUM_REQ = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] c_LAST    = ID_W'(NUM_REQ - 1);

    logic                 r_rst_hold;
    logic                 r_out_valid;
    logic [2:0]           r_out_2;
    logic                 r_out_1;
    logic [ID_W-1:0]      r_out_id;
    logic [ID_W-1:0]      r_rr_ptr;

    logic [NUM_REQ-1:0]   w_rot;
    logic                 w_found;
    logic [ID_W-1:0]      w_off;
    logic [ID_W:0]        w_sum;
    logic [ID_W-1:0]      w_grant_idx;
    logic [NUM_REQ-1:0]   w_grant_oh;
    logic                 w_sel_a;
    logic                 w_sel_b;
    logic [1:0]           w_sel_c;
    logic                 w_can_load;
    logic                 w_xfer;

    // Requester view rotated so bit 0 is the current round-robin head.
    assign w_rot = NUM_REQ'({req_valid, req_valid} >> r_rr_ptr);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = ID_W'(i);
            end
        end
    end

    assign w_sum       = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_grant_idx = (w_sum >= c_NUM_REQ) ? ID_W'(w_sum - c_NUM_REQ) : w_sum[ID_W-1:0];

    always_comb begin
        w_grant_oh = '0;
        w_sel_a    = 1'b0;
        w_sel_b    = 1'b0;
        w_sel_c    = 2'b00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_found && (w_grant_idx == ID_W'(i))) begin
                w_grant_oh[i] = 1'b1;
                w_sel_a       = req_a[i];
                w_sel_b       = req_b[i];
                w_sel_c       = req_c[2*i +: 2];
            end
        end
    end

    // Grants are withheld for one edge after reset release.
    assign w_can_load = !r_rst_hold && (!r_out_valid || out_ready);
    assign req_ready  = w_can_load ? w_grant_oh : '0;
    assign w_xfer     = w_can_load && w_found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_hold <= 1'b1;
        end else begin
            r_rst_hold <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_2     <= 3'b000;
            r_out_1     <= 1'b0;
            r_out_id    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_2     <= {w_sel_a, w_sel_c};
            r_out_1     <= w_sel_b;
            r_out_id    <= w_grant_idx;
            r_rr_ptr    <= (w_grant_idx == c_LAST) ? '0 : w_grant_idx + 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_2     = r_out_2;
    assign out_1     = r_out_1;
    assign out_id    = r_out_id;

`ifdef PROC_CONCAT_ARB_STATS_EN
    logic [15:0] r_stat_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_count <= 16'h0000;
        end else if (w_xfer && (r_stat_count != 16'hFFFF)) begin
            r_stat_count <= r_stat_count + 16'h0001;
        end
    end

    assign stat_count = r_stat_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_proc_concat_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_proc_concat_arbiter                                          |
// | Directed self-checking bench for proc_concat_arbiter (NUM_REQ=4).        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_proc_concat_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic [7:0] req_c;
    logic [3:0] req_ready;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_2;
    logic       out_1;
    logic [2:0] out_id;
`ifdef PROC_CONCAT_ARB_STATS_EN
    logic [15:0] stat_count;
`endif

    int n_vec     = 0;
    int n_miscmp  = 0;

    always #5 clk = ~clk;

    proc_concat_arbiter #(
        .NUM_REQ (4),
        .ID_W    (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_2     (out_2),
        .out_1     (out_1),
        .out_id    (out_id)
`ifdef PROC_CONCAT_ARB_STATS_EN
        ,
        .stat_count(stat_count)
`endif
    );

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin expectations: field tables a=1010, b=0110, c_i=i.
    int exp_id[5] = '{2, 3, 0, 1, 2};
    int exp_o2[4] = '{0, 5, 2, 7};
    int exp_o1[4] = '{0, 1, 1, 0};

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_a     = 4'b0000;
        req_b     = 4'b0000;
        req_c     = 8'h00;
        out_ready = 1'b0;
        repeat (2) tick();

        chk_vec("rst_valid", 32'(out_valid), 0);
        chk_vec("rst_out2",  32'(out_2), 0);
        chk_vec("rst_out1",  32'(out_1), 0);
        chk_vec("rst_id",    32'(out_id), 0);
        chk_vec("rst_ready", 32'(req_ready), 0);

        // Single request from requester 2 right after reset release.
        rst       = 1'b0;
        req_valid = 4'b0100;
        req_a     = 4'b0100;
        req_c     = 8'b0001_0000;
        req_b     = 4'b0000;
        out_ready = 1'b1;
        #1;
        chk_vec("ready_during_release", 32'(req_ready), 0);
        tick();
        chk_vec("valid_first_edge", 32'(out_valid), 0);
        chk_vec("ready_single", 32'(req_ready), 4);
        tick();
        chk_vec("single_valid", 32'(out_valid), 1);
        chk_vec("single_out2",  32'(out_2), 5);
        chk_vec("single_out1",  32'(out_1), 0);
        chk_vec("single_id",    32'(out_id), 2);

        // Pointer at 3, only requester 1 asks: wrap and skip.
        req_valid = 4'b0010;
        req_a     = 4'b0000;
        req_c     = 8'b0000_1000;
        req_b     = 4'b0010;
        #1;
        chk_vec("wrap_ready", 32'(req_ready), 2);
        tick();
        chk_vec("wrap_id",   32'(out_id), 1);
        chk_vec("wrap_out2", 32'(out_2), 2);
        chk_vec("wrap_out1", 32'(out_1), 1);
        req_valid = 4'b1111;
        #1;
        chk_vec("ptr_after_wrap", 32'(req_ready), 4);

        // Continuous round robin, pointer starting at 2.
        req_a = 4'b1010;
        req_b = 4'b0110;
        req_c = 8'b11_10_01_00;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_vec("rr_valid", 32'(out_valid), 1);
            chk_vec("rr_id",    32'(out_id), 32'(exp_id[k]));
            chk_vec("rr_out2",  32'(out_2), 32'(exp_o2[exp_id[k]]));
            chk_vec("rr_out1",  32'(out_1), 32'(exp_o1[exp_id[k]]));
        end

        // Backpressure with word from requester 2 held, pointer at 3.
        out_ready = 1'b0;
        req_valid = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_vec("stall_ready", 32'(req_ready), 0);
            tick();
            chk_vec("stall_valid", 32'(out_valid), 1);
            chk_vec("stall_id",    32'(out_id), 2);
            chk_vec("stall_out2",  32'(out_2), 2);
            chk_vec("stall_out1",  32'(out_1), 1);
        end
        out_ready = 1'b1;
        #1;
        chk_vec("release_ready", 32'(req_ready), 1);
        tick();
        chk_vec("release_id", 32'(out_id), 0);

        req_valid = 4'b0010;
        tick();
        chk_vec("pre_drain_id", 32'(out_id), 1);

        // Drain with no new request: data holds, pointer stays at 2.
        req_valid = 4'b0000;
        tick();
        chk_vec("drain_valid", 32'(out_valid), 0);
        chk_vec("drain_out2",  32'(out_2), 5);
        chk_vec("drain_id",    32'(out_id), 1);
        tick();
        req_valid = 4'b1111;
        #1;
        chk_vec("idle_ptr", 32'(req_ready), 4);
        tick();
        chk_vec("load_before_rst", 32'(out_valid), 1);

        // Asynchronous reset while stalled.
        out_ready = 1'b0;
        req_valid = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        chk_vec("arst_valid", 32'(out_valid), 0);
        chk_vec("arst_out2",  32'(out_2), 0);
        chk_vec("arst_out1",  32'(out_1), 0);
        chk_vec("arst_id",    32'(out_id), 0);
        #1;
        rst       = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk_vec("arst_hold_ready", 32'(req_ready), 0);
        tick();
        chk_vec("arst_ptr_zero", 32'(req_ready), 1);
        tick();
        chk_vec("arst_first_valid", 32'(out_valid), 1);
        chk_vec("arst_first_id",    32'(out_id), 0);

`ifdef PROC_CONCAT_ARB_STATS_EN
        force dut.r_stat_count = 16'hFFFE;
        #1;
        release dut.r_stat_count;
        repeat (3) tick();
        chk_vec("stat_sat", 32'(stat_count), 32'h0000FFFF);
        tick();
        chk_vec("stat_hold", 32'(stat_count), 32'h0000FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/proc_concat_arbiter.md
# proc_concat_arbiter

Round-robin arbiter and sequencer for the shared nested-concatenation register datapath. Up to NUM_REQ requesters each present a field set (a, c, b). One requester is granted per cycle, and its fields are packed into a registered 4-bit word {a, c[1:0], b]. The word is presented on the split outputs out_2/out_1 with a valid/ready handshake. The block sits between the field producers and the single downstream consumer of the packed word.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- ID_W, 3: width of out_id; must satisfy 2^ID_W >= NUM_REQ.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request.
- req_a  input  NUM_REQ  field a, bit i belongs to requester i.
- req_b  input  NUM_REQ  field b, bit i belongs to requester i.
- req_c  input  2*NUM_REQ  field c, bits [2i+1:2i] belong to requester i.
- req_ready  output  NUM_REQ  one-hot or zero; combinational grant/accept.
- out_valid  output  1  packed word held.
- out_ready  input  1  consumer accepts the word.
- out_2  output  3  packed word bits [3:1] = {a, c[1], c[0]}.
- out_1  output  1  packed word bit [0] = b.
- out_id  output  ID_W  index of the requester that produced the held word.

## Operation
- The output stage is a single registered entry.
- It can load when it is free: `!out_valid || out_ready`.
- Arbitration is combinational among requesters with req_valid=1.
  - Search order starts at rr_ptr and wraps modulo NUM_REQ.
  - The first requester found is granted.
- req_ready[g]=1 only for the granted g, and only when the stage can load. All other bits are 0.
- A transfer occurs when req_valid[g] && req_ready[g]. On that clock edge:
  - out_2 <= {req_a[g], req_c[2g+1], req_c[2g]}
  - out_1 <= req_b[g]
  - out_id <= g
  - out_valid <= 1
  - rr_ptr <= (g+1) mod NUM_REQ
- If the stage drains (out_valid && out_ready) with no transfer, out_valid <= 0. Data outputs hold their last value.
- If the stage drains and a transfer happens in the same cycle, the new word loads. out_valid stays 1, giving back-to-back throughput of one word per cycle.
- Under stall (out_valid=1, out_ready=0):
  - all req_ready are 0;
  - out_2, out_1 and out_id are held stable;
  - rr_ptr is unchanged.
- rr_ptr changes only on a transfer.
- Idle cycles, with no req_valid or the stage not free, do not move the pointer.
- Requesters may drop req_valid before acceptance. No grant is latched across cycles.
- Reset values: out_valid=0, out_2=0, out_1=0, out_id=0, rr_ptr=0 (requester 0 highest priority), stat_count=0 when compiled in.
- Reset mid-operation discards the held word immediately (asynchronous).

## Timing
- Latency: a request accepted at edge T is visible on out_* with out_valid=1 after edge T, i.e. in cycle T+1.
- req_ready is combinational from req_valid, rr_ptr, out_valid and out_ready. There is no combinational path from req_a/b/c to any output.
- Fairness: a continuously asserting requester is granted within NUM_REQ transfers.
- Rules at the rr_ptr boundary:
  - When rr_ptr = NUM_REQ-1, granting NUM_REQ-1 wraps the pointer to 0.
  - When rr_ptr points to a requester that is not requesting, the next higher index wins, with wrap-around.
- Deassertion of rst is applied synchronously internally. The first transfer can occur at the second rising edge after rst falls.

## Configuration
- PROC_CONCAT_ARB_STATS_EN defined:
  - adds output port stat_count (16 bits);
  - stat_count increments by 1 on every transfer;
  - it saturates at 16'hFFFF and clears on rst.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then single request:
  - Stimulus: rst pulse; req_valid=4'b0100, req_a[2]=1, req_c[5:4]=2'b01, req_b[2]=0, out_ready=1.
  - Response: req_ready=4'b0100; next cycle out_valid=1, out_2=3'b101, out_1=0, out_id=2.
- Round robin:
  - Stimulus: req_valid=4'b1111 held, out_ready=1.
  - Response: out_id sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
- Backpressure:
  - Stimulus: a word is held with out_ready=0 for 3 cycles while req_valid=4'b0011.
  - Response: req_ready=0, out_* unchanged for 3 cycles. On out_ready=1 the next grant goes to the index after the held out_id.
- Wrap and skip:
  - Stimulus: rr_ptr=3 (after granting 2); req_valid=4'b0010.
  - Response: requester 1 granted; rr_ptr becomes 2.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously while out_valid=1 and out_ready=0.
  - Response: out_valid, out_2, out_1 and out_id go to 0 before the next clk edge; rr_ptr=0.
- STATS_EN saturation:
  - Stimulus: force stat_count=16'hFFFE, then perform 3 transfers.
  - Response: stat_count reads 16'hFFFF and stays there.
